// File: rtl/frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : frame_sync
// Description : Hunts a decoded serial bit stream for a sync word, forwards
//               one frame of payload bits, verifies the trailing XOR checksum
//               byte and aborts the frame when the gap between bits grows too
//               long.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sync #(
  parameter logic [7:0] SYNC_WORD      = 8'hD5,
  parameter int         PAYLOAD_BYTES  = 16,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic serial_clock,
  input  logic serial_data,
  output logic frame_start,
  output logic payload_clock,
  output logic payload_data,
  output logic frame_done,
  output logic frame_ok,
  output logic frame_abort,
  output logic locked
);

  localparam int C_BIT_W = $clog2(PAYLOAD_BYTES * 8);
  localparam int C_GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_BIT_W-1:0] C_LAST_BIT  = C_BIT_W'(PAYLOAD_BYTES * 8 - 1);
  localparam logic [C_GAP_W-1:0] C_TIMEOUT   = C_GAP_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]         C_HUNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  state_t               r_state;
  logic [7:0]           r_shreg;
  logic [3:0]           r_hunt_cnt;
  logic [C_BIT_W-1:0]   r_bit_cnt;
  logic [7:0]           r_csum;
  logic [7:0]           r_rx_csum;
  logic [C_GAP_W-1:0]   r_gap_cnt;
  logic                 r_frame_start;
  logic                 r_payload_clock;
  logic                 r_payload_data;
  logic                 r_frame_done;
  logic                 r_frame_ok;
  logic                 r_frame_abort;
  logic                 r_locked;

  state_t               w_state_nxt;
  logic [7:0]           w_shreg_nxt;
  logic [3:0]           w_hunt_cnt_nxt;
  logic [C_BIT_W-1:0]   w_bit_cnt_nxt;
  logic [7:0]           w_csum_nxt;
  logic [7:0]           w_rx_csum_nxt;
  logic [C_GAP_W-1:0]   w_gap_cnt_nxt;
  logic                 w_frame_start_nxt;
  logic                 w_payload_clock_nxt;
  logic                 w_payload_data_nxt;
  logic                 w_frame_done_nxt;
  logic                 w_frame_ok_nxt;
  logic                 w_frame_abort_nxt;

  // A bit only counts while enabled; an enabled cycle without a bit is idle.
  logic                 w_bit_ev;
  logic                 w_idle;
  logic [7:0]           w_shift;
  logic [3:0]           w_hunt_inc;
  logic [7:0]           w_rx_shift;
  logic [C_GAP_W-1:0]   w_gap_inc;
  logic [C_BIT_W-1:0]   w_bit_inc;
  logic [2:0]           w_csum_idx;

  assign w_bit_ev   = enable & serial_clock;
  assign w_idle     = enable & ~serial_clock;
  assign w_shift    = {r_shreg[6:0], serial_data};
  assign w_hunt_inc = (r_hunt_cnt == C_HUNT_FULL) ? C_HUNT_FULL : (r_hunt_cnt + 4'd1);
  assign w_rx_shift = {r_rx_csum[6:0], serial_data};
  assign w_gap_inc  = r_gap_cnt + C_GAP_W'(1);
  assign w_bit_inc  = r_bit_cnt + C_BIT_W'(1);
  // Payload bits arrive MSB-first within each byte.
  assign w_csum_idx = 3'd7 - r_bit_cnt[2:0];

  // Next-state, counter and output-pulse logic.
  always_comb begin
    w_state_nxt         = r_state;
    w_shreg_nxt         = r_shreg;
    w_hunt_cnt_nxt      = r_hunt_cnt;
    w_bit_cnt_nxt       = r_bit_cnt;
    w_csum_nxt          = r_csum;
    w_rx_csum_nxt       = r_rx_csum;
    w_gap_cnt_nxt       = r_gap_cnt;
    w_frame_start_nxt   = 1'b0;
    w_payload_clock_nxt = 1'b0;
    w_payload_data_nxt  = 1'b0;
    w_frame_done_nxt    = 1'b0;
    w_frame_ok_nxt      = r_frame_ok;
    w_frame_abort_nxt   = 1'b0;

    case (r_state)
      ST_HUNT: begin
        w_gap_cnt_nxt = '0;
        if (w_bit_ev) begin
          w_shreg_nxt    = w_shift;
          w_hunt_cnt_nxt = w_hunt_inc;
          // Require 8 fresh bits since entering HUNT before a match counts.
          if ((w_shift == SYNC_WORD) && (w_hunt_inc == C_HUNT_FULL)) begin
            w_state_nxt       = ST_PAYLOAD;
            w_bit_cnt_nxt     = '0;
            w_csum_nxt        = '0;
            w_frame_start_nxt = 1'b1;
          end
        end
      end

      ST_PAYLOAD, ST_CHECK: begin
        // A bit arriving in the timeout cycle takes priority over the abort.
        if (w_bit_ev) begin
          w_gap_cnt_nxt = '0;
          if (r_state == ST_PAYLOAD) begin
            w_payload_clock_nxt    = 1'b1;
            w_payload_data_nxt     = serial_data;
            w_csum_nxt[w_csum_idx] = r_csum[w_csum_idx] ^ serial_data;
            if (r_bit_cnt == C_LAST_BIT) begin
              w_state_nxt   = ST_CHECK;
              w_bit_cnt_nxt = '0;
            end else begin
              w_bit_cnt_nxt = w_bit_inc;
            end
          end else begin
            w_rx_csum_nxt = w_rx_shift;
            if (r_bit_cnt[2:0] == 3'd7) begin
              w_frame_ok_nxt   = (w_rx_shift == r_csum);
              w_frame_done_nxt = 1'b1;
              w_state_nxt      = ST_HUNT;
              w_shreg_nxt      = '0;
              w_hunt_cnt_nxt   = '0;
              w_bit_cnt_nxt    = '0;
            end else begin
              w_bit_cnt_nxt = w_bit_inc;
            end
          end
        end else if (w_idle) begin
          w_gap_cnt_nxt = w_gap_inc;
          if (w_gap_inc == C_TIMEOUT) begin
            w_frame_abort_nxt = 1'b1;
            w_state_nxt       = ST_HUNT;
            w_shreg_nxt       = '0;
            w_hunt_cnt_nxt    = '0;
            w_bit_cnt_nxt     = '0;
            w_gap_cnt_nxt     = '0;
          end
        end
      end

      default: begin
        w_state_nxt    = ST_HUNT;
        w_shreg_nxt    = '0;
        w_hunt_cnt_nxt = '0;
        w_gap_cnt_nxt  = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_HUNT;
      r_shreg         <= '0;
      r_hunt_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_csum          <= '0;
      r_rx_csum       <= '0;
      r_gap_cnt       <= '0;
      r_frame_start   <= 1'b0;
      r_payload_clock <= 1'b0;
      r_payload_data  <= 1'b0;
      r_frame_done    <= 1'b0;
      r_frame_ok      <= 1'b0;
      r_frame_abort   <= 1'b0;
      r_locked        <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_shreg         <= w_shreg_nxt;
      r_hunt_cnt      <= w_hunt_cnt_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_csum          <= w_csum_nxt;
      r_rx_csum       <= w_rx_csum_nxt;
      r_gap_cnt       <= w_gap_cnt_nxt;
      r_frame_start   <= w_frame_start_nxt;
      r_payload_clock <= w_payload_clock_nxt;
      r_payload_data  <= w_payload_data_nxt;
      r_frame_done    <= w_frame_done_nxt;
      r_frame_ok      <= w_frame_ok_nxt;
      r_frame_abort   <= w_frame_abort_nxt;
      r_locked        <= (w_state_nxt != ST_HUNT);
    end
  end

  assign frame_start   = r_frame_start;
  assign payload_clock = r_payload_clock;
  assign payload_data  = r_payload_data;
  assign frame_done    = r_frame_done;
  assign frame_ok      = r_frame_ok;
  assign frame_abort   = r_frame_abort;
  assign locked        = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_frame_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_sync
// Description : Directed self-checking bench for frame_sync.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sync;

  logic clock;
  logic reset_n;
  logic enable;
  logic serial_clock;
  logic serial_data;
  logic frame_start;
  logic payload_clock;
  logic payload_data;
  logic frame_done;
  logic frame_ok;
  logic frame_abort;
  logic locked;

  int checks   = 0;
  int failures = 0;

  int n_start = 0, n_pclk = 0, n_done = 0, n_abort = 0;
  int s_start, s_pclk, s_done, s_abort;
  logic [127:0] cap = '0;

  logic [7:0]   sw   = 8'hD5;
  logic [127:0] pay  = 128'h000102030405060708090A0B0C0D0E0F;
  logic [127:0] pay2 = 128'hDEADBEEF00000000000000000000A5C3;

  frame_sync #(
    .SYNC_WORD      (8'hD5),
    .PAYLOAD_BYTES  (16),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .serial_clock  (serial_clock),
    .serial_data   (serial_data),
    .frame_start   (frame_start),
    .payload_clock (payload_clock),
    .payload_data  (payload_data),
    .frame_done    (frame_done),
    .frame_ok      (frame_ok),
    .frame_abort   (frame_abort),
    .locked        (locked)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters and payload capture, sampled 2 ns after each rising edge.
  always @(posedge clock) begin
    #2;
    if (frame_start)   n_start = n_start + 1;
    if (frame_done)    n_done  = n_done + 1;
    if (frame_abort)   n_abort = n_abort + 1;
    if (payload_clock) begin
      n_pclk = n_pclk + 1;
      cap    = {cap[126:0], payload_data};
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_start = n_start;
    s_pclk  = n_pclk;
    s_done  = n_done;
    s_abort = n_abort;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      serial_clock = 1'b0;
    end
  endtask

  // One bit event followed by (sp-1) quiet cycles.
  task automatic send_bit(input logic b, input int sp);
    @(negedge clock);
    serial_clock = 1'b1;
    serial_data  = b;
    for (int i = 1; i < sp; i++) begin
      @(negedge clock);
      serial_clock = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int sp);
    for (int i = 7; i >= 0; i--) send_bit(v[i], sp);
  endtask

  task automatic send_payload(input logic [127:0] v, input int sp);
    for (int i = 127; i >= 0; i--) send_bit(v[i], sp);
  endtask

  task automatic send_frame(input logic [127:0] v, input logic [7:0] cs, input int sp);
    send_byte(sw, sp);
    send_payload(v, sp);
    send_byte(cs, sp);
    idle(4);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n      = 1'b0;
    serial_clock = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b1;
    serial_clock = 1'b0;
    serial_data  = 1'b0;
    do_reset();

    // Reset state
    chk("reset_outputs",
        {frame_start, payload_clock, payload_data, frame_done, frame_ok, frame_abort, locked}, 0);

    // Hunting through a false candidate: 0xAA then 0xD5, exact frame_start timing
    snap();
    send_byte(8'hAA, 4);
    for (int i = 7; i >= 1; i--) send_bit(sw[i], 4);
    @(negedge clock);
    serial_clock = 1'b1;
    serial_data  = sw[0];
    chk("hunt_no_early_start", n_start - s_start, 0);
    @(negedge clock);
    serial_clock = 1'b0;
    chk("hunt_start_pulse", frame_start, 1);
    chk("hunt_locked_rise", locked, 1);
    @(negedge clock);
    chk("hunt_start_one_cycle", frame_start, 0);
    chk("hunt_start_count", n_start - s_start, 1);
    do_reset();

    // Only seven sync bits after reset: no lock, eighth bit completes it
    snap();
    for (int i = 7; i >= 1; i--) send_bit(sw[i], 4);
    idle(4);
    chk("seven_bits_no_start", n_start - s_start, 0);
    chk("seven_bits_unlocked", locked, 0);
    send_bit(sw[0], 4);
    chk("eighth_bit_start", n_start - s_start, 1);
    do_reset();

    // Clean frame, 8-cycle bit spacing
    snap();
    send_frame(pay, 8'h00, 8);
    chk("clean_start_count", n_start - s_start, 1);
    chk("clean_pclk_count", n_pclk - s_pclk, 128);
    chk("clean_payload", cap, pay);
    chk("clean_done_count", n_done - s_done, 1);
    chk("clean_ok", frame_ok, 1);
    chk("clean_unlocked", locked, 0);

    // Timeout after 40 payload bits; frame_ok must keep its value of 1
    snap();
    send_byte(sw, 8);
    for (int i = 127; i > 88; i--) send_bit(pay[i], 8);
    @(negedge clock);
    serial_clock = 1'b1;
    serial_data  = pay[88];
    @(negedge clock);
    serial_clock = 1'b0;
    repeat (1023) @(negedge clock);
    chk("timeout_not_yet", frame_abort, 0);
    chk("timeout_still_locked", locked, 1);
    @(negedge clock);
    chk("timeout_abort", frame_abort, 1);
    chk("timeout_unlocked", locked, 0);
    chk("timeout_ok_kept", frame_ok, 1);
    @(negedge clock);
    chk("timeout_abort_one_cycle", frame_abort, 0);
    chk("timeout_no_done", n_done - s_done, 0);
    chk("timeout_pclk_count", n_pclk - s_pclk, 40);

    // Clean frame after abort locks normally
    snap();
    send_frame(pay, 8'h00, 8);
    chk("post_abort_start", n_start - s_start, 1);
    chk("post_abort_ok", frame_ok, 1);

    // Bad checksum
    snap();
    send_frame(pay, 8'h01, 8);
    chk("bad_done_count", n_done - s_done, 1);
    chk("bad_ok", frame_ok, 0);

    // Enable low for 5000 cycles mid-payload, with ignored serial_clock pulses
    snap();
    send_byte(sw, 8);
    for (int i = 127; i >= 88; i--) send_bit(pay[i], 8);
    @(negedge clock);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      serial_clock = 1'b1;
      serial_data  = 1'b1;
      @(negedge clock);
      serial_clock = 1'b0;
      chk("disabled_no_pclk", payload_clock, 0);
    end
    repeat (4994) @(negedge clock);
    chk("disabled_locked_held", locked, 1);
    chk("disabled_pclk_count", n_pclk - s_pclk, 40);
    enable = 1'b1;
    for (int i = 87; i >= 0; i--) send_bit(pay[i], 8);
    send_byte(8'h00, 8);
    idle(4);
    chk("enable_no_abort", n_abort - s_abort, 0);
    chk("enable_done_count", n_done - s_done, 1);
    chk("enable_payload", cap, pay);
    chk("enable_ok", frame_ok, 1);

    // Two back-to-back frames at 1-cycle bit spacing
    snap();
    send_byte(sw, 1);
    send_payload(pay, 1);
    send_byte(8'h00, 1);
    send_byte(sw, 1);
    send_payload(pay2, 1);
    send_byte(8'h44, 1);
    idle(4);
    chk("b2b_start_count", n_start - s_start, 2);
    chk("b2b_done_count", n_done - s_done, 2);
    chk("b2b_pclk_count", n_pclk - s_pclk, 256);
    chk("b2b_payload", cap, pay2);
    chk("b2b_ok", frame_ok, 1);

    // Asynchronous reset after 60 payload bits
    snap();
    send_byte(sw, 8);
    for (int i = 127; i >= 68; i--) send_bit(pay[i], 8);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs",
        {frame_start, payload_clock, payload_data, frame_done, frame_ok, frame_abort, locked}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("midreset_no_abort", n_abort - s_abort, 0);
    snap();
    send_frame(pay, 8'h00, 8);
    chk("midreset_next_start", n_start - s_start, 1);
    chk("midreset_next_ok", frame_ok, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
